// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone SDRAM arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Width needed to index n things, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin requester search: picks the first set req after ptr, wrapping.
module rr_priority_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          any
);

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    logic [IW-1:0] idx;
    sel = '0;
    idx = '0;
    any = |req;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) sel = idx;
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between N masters.
// A whole bus cycle is granted to one master; the bus is only released once
// every accepted request of that cycle has been acked, so acks never misroute.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; all masters stalled, arbitrate among cyc requesters
// ST_OWN   | master gnt owns the bus; requests forwarded, acks routed back
// ST_DRAIN | owner dropped cyc with acks pending; wait for them, no new stb
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_BITS       = 23,
  parameter int DATA_BYTES      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              sresetn,
  input  logic [N_MASTERS-1:0]              s_wb_cyc,
  input  logic [N_MASTERS-1:0]              s_wb_stb,
  input  logic [N_MASTERS-1:0]              s_wb_we,
  input  logic [N_MASTERS*ADDR_BITS-1:0]    s_wb_addr,
  input  logic [N_MASTERS*DATA_BYTES*8-1:0] s_wb_dat_m2s,
  output logic [N_MASTERS-1:0]              s_wb_stall,
  output logic [N_MASTERS-1:0]              s_wb_ack,
  output logic [DATA_BYTES*8-1:0]           s_wb_dat_s2m,
  output logic                              m_wb_cyc,
  output logic                              m_wb_stb,
  output logic                              m_wb_we,
  output logic [ADDR_BITS-1:0]              m_wb_addr,
  output logic [DATA_BYTES*8-1:0]           m_wb_dat_m2s,
  input  logic                              m_wb_stall,
  input  logic                              m_wb_ack,
  input  logic [DATA_BYTES*8-1:0]           m_wb_dat_s2m,
  output logic [idx_width(N_MASTERS)-1:0]   grant_idx
);

  localparam int IW = idx_width(N_MASTERS);
  localparam int CW = idx_width(MAX_OUTSTANDING + 1);
  localparam int DW = DATA_BYTES * 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  arb_state_t    state;
  logic [IW-1:0] gnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          any;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          g_cyc;
  logic          g_stb;
  logic          full;
  logic          accept;
  logic          ack_ok;

  rr_priority_select #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_sel (
    .req (s_wb_cyc),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  // Bus muxing, stall/ack routing and outstanding-count bookkeeping.
  always_comb begin
    g_cyc  = s_wb_cyc[gnt];
    g_stb  = s_wb_stb[gnt];
    full   = (cnt == CNT_MAX);

    m_wb_cyc     = (state != ST_IDLE);
    m_wb_stb     = (state == ST_OWN) && g_cyc && g_stb && !full;
    m_wb_we      = s_wb_we[gnt];
    m_wb_addr    = s_wb_addr[int'(gnt)*ADDR_BITS +: ADDR_BITS];
    m_wb_dat_m2s = s_wb_dat_m2s[int'(gnt)*DW +: DW];
    s_wb_dat_s2m = m_wb_dat_s2m;

    accept = m_wb_stb && !m_wb_stall;
    // An ack with nothing outstanding belongs to no one (stale or spurious).
    ack_ok = m_wb_ack && (cnt != '0) && (state != ST_IDLE);
    cnt_nxt = cnt + CW'(accept) - CW'(ack_ok);

    s_wb_ack      = '0;
    s_wb_ack[gnt] = ack_ok;
    s_wb_stall    = '1;
    if (state == ST_OWN) s_wb_stall[gnt] = m_wb_stall || full;

    grant_idx = gnt;
  end

  // Arbitration state, grant, fairness pointer and outstanding count.
  always_ff @(posedge clk or posedge sresetn) begin
    if (sresetn) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ptr   <= IW'(N_MASTERS - 1);
      cnt   <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        ST_IDLE: begin
          if (any) begin
            state <= ST_OWN;
            gnt   <= sel;
            ptr   <= sel;
          end
        end
        ST_OWN: begin
          if (!g_cyc) state <= (cnt_nxt == '0) ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cnt_nxt == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: per-master request queues feed the
// masters, accepted requests are checked at the slave side and their owner is
// queued so each slave ack can be checked against the master it must reach.
module tb_wb_sdram_arbiter;

  localparam int N  = 2;
  localparam int AB = 23;
  localparam int DB = 2;
  localparam int DW = DB * 8;
  localparam int MO = 4;

  typedef struct packed {
    logic          we;
    logic [AB-1:0] addr;
    logic [DW-1:0] dat;
  } req_t;

  logic            clk = 1'b0;
  logic            sresetn = 1'b1;
  logic [N-1:0]    s_wb_cyc, s_wb_stb, s_wb_we;
  logic [N*AB-1:0] s_wb_addr;
  logic [N*DW-1:0] s_wb_dat_m2s;
  logic [N-1:0]    s_wb_stall, s_wb_ack;
  logic [DW-1:0]   s_wb_dat_s2m;
  logic            m_wb_cyc, m_wb_stb, m_wb_we;
  logic [AB-1:0]   m_wb_addr;
  logic [DW-1:0]   m_wb_dat_m2s;
  logic            m_wb_stall, m_wb_ack;
  logic [DW-1:0]   m_wb_dat_s2m;
  logic [0:0]      grant_idx;

  req_t         mq0[$];
  req_t         mq1[$];
  int           ack_q[$];
  logic [N-1:0] cyc_en;
  int           exp_gnt;
  int           accepted;
  int           guard;
  int           total = 0;
  int           bad = 0;

  wb_sdram_arbiter #(
    .N_MASTERS(N), .ADDR_BITS(AB), .DATA_BYTES(DB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .sresetn(sresetn),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
    .s_wb_addr(s_wb_addr), .s_wb_dat_m2s(s_wb_dat_m2s),
    .s_wb_stall(s_wb_stall), .s_wb_ack(s_wb_ack), .s_wb_dat_s2m(s_wb_dat_s2m),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
    .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s),
    .m_wb_stall(m_wb_stall), .m_wb_ack(m_wb_ack), .m_wb_dat_s2m(m_wb_dat_s2m),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_req(input int m, input logic we, input logic [AB-1:0] a,
                          input logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.dat = d;
    if (m == 0) mq0.push_back(r);
    else        mq1.push_back(r);
  endtask

  // Present each master's head request while its cycle is enabled.
  task automatic apply();
    s_wb_cyc = cyc_en;
    s_wb_stb = '0; s_wb_we = '0; s_wb_addr = '0; s_wb_dat_m2s = '0;
    if (cyc_en[0] && mq0.size() > 0) begin
      s_wb_stb[0] = 1'b1; s_wb_we[0] = mq0[0].we;
      s_wb_addr[AB-1:0] = mq0[0].addr; s_wb_dat_m2s[DW-1:0] = mq0[0].dat;
    end
    if (cyc_en[1] && mq1.size() > 0) begin
      s_wb_stb[1] = 1'b1; s_wb_we[1] = mq1[0].we;
      s_wb_addr[2*AB-1:AB] = mq1[0].addr; s_wb_dat_m2s[2*DW-1:DW] = mq1[0].dat;
    end
    #1;
  endtask

  // Scoreboard: acks pop the oldest owner, accepts pop the granted master's head.
  task automatic monitor();
    req_t r;
    int   o;
    if (m_wb_ack) begin
      if (ack_q.size() > 0) begin
        o = ack_q.pop_front();
        chk("ack_route", 64'(s_wb_ack), 64'(1) << o);
      end else begin
        chk("ack_spurious", 64'(s_wb_ack), 0);
      end
    end
    if (m_wb_stb && !m_wb_stall) begin
      accepted++;
      if ((exp_gnt == 0 && mq0.size() == 0) || (exp_gnt == 1 && mq1.size() == 0)) begin
        chk("accept_unexpected", 64'(m_wb_stb), 0);
      end else begin
        if (exp_gnt == 0) r = mq0.pop_front();
        else              r = mq1.pop_front();
        chk("req_addr", 64'(m_wb_addr), 64'(r.addr));
        chk("req_we", 64'(m_wb_we), 64'(r.we));
        chk("req_dat", 64'(m_wb_dat_m2s), 64'(r.dat));
        chk("req_stall_gnt", 64'(s_wb_stall[exp_gnt]), 0);
        ack_q.push_back(exp_gnt);
      end
    end
  endtask

  task automatic tick();
    apply();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sresetn = 1'b1;
    cyc_en = '0; m_wb_ack = 1'b0; m_wb_stall = 1'b0; m_wb_dat_s2m = 16'hA5C3;
    mq0.delete(); mq1.delete(); ack_q.delete(); accepted = 0; exp_gnt = 0;
    @(posedge clk); #1;
    apply();
    chk("rst_cyc", 64'(m_wb_cyc), 0);
    chk("rst_stb", 64'(m_wb_stb), 0);
    chk("rst_stall", 64'(s_wb_stall), 2'b11);
    chk("rst_gidx", 64'(grant_idx), 0);
    @(posedge clk); #1;
    sresetn = 1'b0;
  endtask

  task automatic ack_all();
    m_wb_ack = 1'b1;
    guard = 0;
    while (ack_q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    m_wb_ack = 1'b0;
    chk("ack_bound", 64'(guard < 20), 1);
  endtask

  initial begin
    // Master 0 alone: single write.
    do_reset();
    push_req(0, 1'b1, 23'h000000, 16'h5555);
    cyc_en = 2'b01;
    apply();
    chk("t1_idle_stb", 64'(m_wb_stb), 0);
    chk("t1_idle_stall", 64'(s_wb_stall), 2'b11);
    tick();
    apply();
    chk("t1_stb_after_1", 64'(m_wb_stb), 1);
    chk("t1_s2m_bcast", 64'(s_wb_dat_s2m), 16'hA5C3);
    tick();
    m_wb_ack = 1'b1; cyc_en = 2'b00;
    tick();
    m_wb_ack = 1'b0;
    apply();
    chk("t1_back_idle", 64'(m_wb_cyc), 0);
    chk("t1_accepted", 64'(accepted), 1);

    // Both masters contend: 0, then 1, then 0 again.
    do_reset();
    push_req(0, 1'b0, 23'h000010, 16'h0);
    push_req(1, 1'b0, 23'h000020, 16'h0);
    cyc_en = 2'b11;
    tick();
    apply();
    chk("t2_first_gnt", 64'(grant_idx), 0);
    chk("t2_stall_other", 64'(s_wb_stall), 2'b10);
    exp_gnt = 0;
    tick();
    m_wb_ack = 1'b1; cyc_en = 2'b10;
    tick();
    m_wb_ack = 1'b0;
    apply();
    chk("t2_idle_stall", 64'(s_wb_stall), 2'b11);
    tick();
    apply();
    chk("t2_second_gnt", 64'(grant_idx), 1);
    exp_gnt = 1;
    tick();
    m_wb_ack = 1'b1; cyc_en = 2'b00;
    tick();
    m_wb_ack = 1'b0;
    push_req(0, 1'b1, 23'h000030, 16'h1234);
    push_req(1, 1'b1, 23'h000040, 16'h4321);
    cyc_en = 2'b11;
    tick();
    apply();
    chk("t2_third_gnt", 64'(grant_idx), 0);
    exp_gnt = 0;
    tick();
    m_wb_ack = 1'b1; cyc_en = 2'b10;
    tick();
    m_wb_ack = 1'b0;
    tick();
    exp_gnt = 1;
    tick();
    m_wb_ack = 1'b1; cyc_en = 2'b00;
    tick();
    m_wb_ack = 1'b0;
    chk("t2_accepted", 64'(accepted), 4);

    // Six pipelined reads against a slave that withholds acks.
    do_reset();
    for (int i = 0; i < 6; i++) push_req(0, 1'b0, 23'(32'h100 + i), 16'h0);
    cyc_en = 2'b01;
    tick();
    for (int i = 0; i < 6; i++) tick();
    apply();
    chk("t3_full_stall", 64'(s_wb_stall[0]), 1);
    chk("t3_full_stb", 64'(m_wb_stb), 0);
    chk("t3_accepted_4", 64'(accepted), 4);
    ack_all();
    chk("t3_accepted_6", 64'(accepted), 6);
    cyc_en = 2'b00;
    tick();
    apply();
    chk("t3_idle", 64'(m_wb_cyc), 0);

    // Owner drops cyc with three reads in flight: drain before master 1.
    do_reset();
    for (int i = 0; i < 3; i++) push_req(0, 1'b0, 23'(32'h200 + i), 16'h0);
    push_req(1, 1'b0, 23'h000300, 16'h0);
    cyc_en = 2'b01;
    tick();
    for (int i = 0; i < 3; i++) tick();
    cyc_en = 2'b10;
    tick();
    apply();
    chk("t4_drain_cyc", 64'(m_wb_cyc), 1);
    chk("t4_drain_stb", 64'(m_wb_stb), 0);
    chk("t4_drain_stall", 64'(s_wb_stall), 2'b11);
    for (int i = 0; i < 3; i++) begin
      m_wb_ack = 1'b1;
      tick();
      m_wb_ack = 1'b0;
      apply();
      chk("t4_drain_hold", 64'(s_wb_stall), 2'b11);
      if (i < 2) tick();
    end
    chk("t4_idle_after", 64'(m_wb_cyc), 0);
    tick();
    apply();
    chk("t4_gnt1", 64'(grant_idx), 1);
    chk("t4_stall1", 64'(s_wb_stall), 2'b01);
    exp_gnt = 1;
    tick();
    m_wb_ack = 1'b1; cyc_en = 2'b00;
    tick();
    m_wb_ack = 1'b0;

    // Accept and ack together at two outstanding, then a spurious ack in idle.
    do_reset();
    for (int i = 0; i < 3; i++) push_req(0, 1'b0, 23'(32'h400 + i), 16'h0);
    cyc_en = 2'b01;
    tick();
    tick();
    tick();
    m_wb_ack = 1'b1;
    tick();
    m_wb_ack = 1'b0;
    apply();
    chk("t5_not_full", 64'(s_wb_stall[0]), 0);
    for (int i = 0; i < 3; i++) push_req(0, 1'b0, 23'(32'h410 + i), 16'h0);
    tick();
    tick();
    apply();
    chk("t5_full_at_4", 64'(s_wb_stall[0]), 1);
    chk("t5_accepted", 64'(accepted), 5);
    ack_all();
    cyc_en = 2'b00;
    tick();
    m_wb_ack = 1'b1;
    apply();
    chk("t5_spurious", 64'(s_wb_ack), 0);
    tick();
    m_wb_ack = 1'b0;
    apply();
    chk("t5_still_idle", 64'(m_wb_cyc), 0);

    // Reset while three reads are outstanding.
    do_reset();
    for (int i = 0; i < 3; i++) push_req(0, 1'b0, 23'(32'h500 + i), 16'h0);
    cyc_en = 2'b01;
    tick();
    for (int i = 0; i < 3; i++) tick();
    sresetn = 1'b1;
    #1;
    chk("t6_rst_cyc", 64'(m_wb_cyc), 0);
    chk("t6_rst_stb", 64'(m_wb_stb), 0);
    chk("t6_rst_stall", 64'(s_wb_stall), 2'b11);
    chk("t6_rst_gidx", 64'(grant_idx), 0);
    cyc_en = 2'b00; mq0.delete(); ack_q.delete();
    @(posedge clk); #1;
    sresetn = 1'b0;
    m_wb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply();
      chk("t6_no_stale_ack", 64'(s_wb_ack), 0);
      tick();
    end
    m_wb_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sdram_arbiter.md
Name: wb_sdram_arbiter

Overview:
- Round-robin arbiter that shares one pipelined Wishbone slave (wb_sdram) between N pipelined Wishbone masters, e.g. serial_wb_master plus a DMA/video reader.
- Grants a whole bus cycle (cyc high) to one master and tracks outstanding acks.
- Releases the bus only after every accepted request of that cycle has been acked, so acks are never misrouted.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8)
ADDR_BITS, 23, Wishbone word address width
DATA_BYTES, 2, data bus width in bytes
MAX_OUTSTANDING, 4, maximum accepted-but-unacked requests in flight (power of 2 not required, >=1)

Ports:
clk  in  1  clock
sresetn  in  1  reset, asynchronous, active-high
s_wb_cyc  in  N_MASTERS  per-master bus cycle request
s_wb_stb  in  N_MASTERS  per-master strobe
s_wb_we  in  N_MASTERS  per-master write enable
s_wb_addr  in  N_MASTERS*ADDR_BITS  per-master address, master i at slice i
s_wb_dat_m2s  in  N_MASTERS*DATA_BYTES*8  per-master write data
s_wb_stall  out  N_MASTERS  per-master stall
s_wb_ack  out  N_MASTERS  per-master ack
s_wb_dat_s2m  out  DATA_BYTES*8  read data, broadcast to all masters
m_wb_cyc  out  1  cycle to slave
m_wb_stb  out  1  strobe to slave
m_wb_we  out  1  write enable to slave
m_wb_addr  out  ADDR_BITS  address to slave
m_wb_dat_m2s  out  DATA_BYTES*8  write data to slave
m_wb_stall  in  1  slave stall
m_wb_ack  in  1  slave ack
m_wb_dat_s2m  in  DATA_BYTES*8  slave read data
grant_idx  out  $clog2(N_MASTERS) (min 1)  currently/last granted master, debug

Behaviour:
- Registered state: fsm {IDLE, OWN, DRAIN}, gnt (index), ptr (last granted index), cnt (0..MAX_OUTSTANDING).
- Reset: fsm=IDLE, gnt=0, ptr=N_MASTERS-1, cnt=0.
- Outputs are combinational from this state, so during reset: m_wb_cyc=0, m_wb_stb=0, s_wb_ack=0, s_wb_stall=all 1, grant_idx=0.
- IDLE:
  - If any s_wb_cyc is high, select the first requester searching ptr+1, ptr+2, ... (mod N_MASTERS).
  - Next cycle: fsm=OWN, gnt=sel, ptr=sel.
  - All stalls are 1 in IDLE, so arbitration costs one cycle of latency.
- OWN:
  - m_wb_cyc=1.
  - m_wb_stb = s_wb_stb[gnt] && cnt<MAX_OUTSTANDING.
  - The address, data and we muxes select master gnt.
  - s_wb_stall[gnt] = m_wb_stall || cnt==MAX_OUTSTANDING; non-granted stalls are 1.
- Accepted request: m_wb_stb && !m_wb_stall.
- cnt update:
  - cnt+1 on an accept only.
  - cnt-1 on m_wb_ack only.
  - Unchanged when both occur in the same cycle.
- A spurious m_wb_ack while cnt==0 is ignored: no forward, cnt stays 0.
- s_wb_ack[gnt] = m_wb_ack && cnt!=0 in OWN and DRAIN. Ack latency through the arbiter is 0 cycles.
- OWN exit when s_wb_cyc[gnt]==0:
  - next cnt==0 → IDLE;
  - otherwise → DRAIN.
  - An stb while cyc is low is ignored and not forwarded.
- DRAIN:
  - m_wb_cyc=1, m_wb_stb=0, all stalls 1, acks still routed to gnt.
  - When next cnt==0 → IDLE.
  - If master gnt re-raises cyc during DRAIN it is not regranted directly; it competes in IDLE.
- Fairness: the ptr rotation guarantees every requesting master is granted within N_MASTERS-1 other cycles. A master holding cyc indefinitely is allowed (no timeout).
- Reset mid-operation: state clears immediately; in-flight slave acks arriving after reset are dropped because cnt==0.
- The index width uses max(1,$clog2(N_MASTERS)).

Decomposition:
- Package wb_arb_pkg: fsm state enum typedef, and a clog2-based index-width helper function.
- Sub-module rr_priority_select: combinational; inputs req[N] and ptr; outputs sel and any. Tested standalone.

Test Plan:
- Master 0 alone: cyc=1, writes 0x5555 @0x000000 → m_wb_stb appears 1 cycle after cyc; slave ack routed only to s_wb_ack[0]; returns to IDLE cnt=0.
- Both masters raise cyc in the same cycle after reset → master 0 granted first. After its cyc drops, master 1 is granted; the next contest after that goes to master 0.
- Master 0 pipelines 6 reads with the slave holding ack off → exactly 4 accepted, s_wb_stall[0]=1 at cnt=4. Acks free slots; all 6 acked in order.
- Master 0 issues 3 reads, then drops cyc before any ack → DRAIN. Master 1's cyc is stalled until the 3rd ack, then master 1 is granted the cycle after IDLE. Master 1 sees no ack belonging to master 0.
- Ack and accept in the same cycle at cnt=2 → cnt stays 2. A spurious ack in IDLE → no s_wb_ack pulse.
- Assert sresetn while cnt=3 in OWN → outputs return to reset values immediately; later slave acks are not forwarded.
